// File: rtl/sdram_arb_pkg.sv
// Shared types and default parameters for the SDRAM host/refresh arbiter.
// The optional host watchdog is enabled with SDRAM_ARB_WATCHDOG_EN (see sdram_arbiter).
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HOST    = 3'd2,
    ST_REFRESH = 3'd3,
    ST_GAP     = 3'd4
  } arb_state_t;

  localparam int DEF_REF_INTERVAL = 390;
  localparam int DEF_MAX_PENDING  = 8;
  localparam int DEF_HOST_TIMEOUT = 64;

endpackage

// File: rtl/sdram_arbiter_refresh_timer.sv
// Refresh tick generator plus the owed-refresh counter and sticky overrun flag.
module refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int MAX_PENDING  = DEF_MAX_PENDING
) (
  input  logic       MEMCLK,
  input  logic       RESET_n,
  input  logic       hold,
  input  logic       ref_dec,
  input  logic       overrun_clr,
  output logic [3:0] ref_pending,
  output logic       ref_overrun
);

  localparam int              CW     = $clog2(REF_INTERVAL + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(REF_INTERVAL - 1);
  localparam logic [3:0]      PMAX   = 4'(MAX_PENDING);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          at_max;

  // hold covers both the INIT state and the cycle that returns to it
  assign tick   = !hold && (tick_cnt == '0);
  assign at_max = (ref_pending == PMAX);

  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      tick_cnt    <= RELOAD;
      ref_pending <= 4'd0;
      ref_overrun <= 1'b0;
    end else begin
      if (hold) begin
        tick_cnt    <= RELOAD;
        ref_pending <= 4'd0;
      end else begin
        tick_cnt <= tick ? RELOAD : tick_cnt - CW'(1);
        if (tick && !ref_dec && !at_max)
          ref_pending <= ref_pending + 4'd1;
        else if (ref_dec && !tick && (ref_pending != 4'd0))
          ref_pending <= ref_pending - 4'd1;
      end
      // a fresh overrun event outranks a watchdog clear in the same cycle
      if (tick && at_max)
        ref_overrun <= 1'b1;
      else if (overrun_clr)
        ref_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM between Zorro host cycles and auto-refresh, with a one-cycle turnaround gap.
// Define SDRAM_ARB_WATCHDOG_EN to abort host cycles that exceed HOST_TIMEOUT cycles.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int MAX_PENDING  = DEF_MAX_PENDING,
  parameter int HOST_TIMEOUT = DEF_HOST_TIMEOUT
) (
  input  logic       MEMCLK,
  input  logic       RESET_n,
  input  logic       init_done,
  input  logic       host_req,
  input  logic       host_done,
  input  logic       ref_done,
  output logic       host_gnt,
  output logic       ref_gnt,
  output logic [3:0] ref_pending,
  output logic       ref_overrun,
  output logic       host_abort,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] PMAX = 4'(MAX_PENDING);

  arb_state_t state, state_nxt;
  logic       hold;
  logic       wd_expire;

  assign hold      = (state == ST_INIT) || !init_done;
  assign state_dbg = state;

  refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_PENDING  (MAX_PENDING)
  ) u_timer (
    .MEMCLK      (MEMCLK),
    .RESET_n     (RESET_n),
    .hold        (hold),
    .ref_dec     (ref_done && ref_gnt),
    .overrun_clr (host_abort),
    .ref_pending (ref_pending),
    .ref_overrun (ref_overrun)
  );

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WW = $clog2(HOST_TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // wd_cnt holds (host grant cycles so far - 1) while in HOST
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n || (state != ST_HOST))
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WW'(1);
  end

  assign wd_expire = (state == ST_HOST) && !host_done && (wd_cnt == WW'(HOST_TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if ((state != ST_INIT) && !init_done) begin
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_INIT:    if (init_done) state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (ref_pending == PMAX)      state_nxt = ST_REFRESH;
          else if (host_req)            state_nxt = ST_HOST;
          else if (ref_pending != 4'd0) state_nxt = ST_REFRESH;
        end
        ST_HOST:    if (host_done || wd_expire) state_nxt = ST_GAP;
        ST_REFRESH: if (ref_done) state_nxt = ST_GAP;
        ST_GAP:     state_nxt = ST_IDLE;
        default:    state_nxt = ST_INIT;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      state      <= ST_INIT;
      host_gnt   <= 1'b0;
      ref_gnt    <= 1'b0;
      host_abort <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      host_gnt   <= (state_nxt == ST_HOST);
      ref_gnt    <= (state_nxt == ST_REFRESH);
      host_abort <= wd_expire && (state_nxt == ST_GAP);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REF_INTERVAL, default 390: MEMCLK cycles between refresh ticks.
REQ-002 Parameter MAX_PENDING, default 8: postponed-refresh limit; range 1..15.
REQ-003 Parameter HOST_TIMEOUT, default 64: watchdog limit in MEMCLK cycles.
REQ-004 MEMCLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RESET_n  input  1  reset, synchronous and active-low.
REQ-006 init_done  input  1  SDRAM power-up init complete.
REQ-007 host_req  input  1  Zorro RAM cycle pending (ram_access and AS asserted).
REQ-008 host_done  input  1  one-cycle pulse: SDRAM controller finished host cycle.
REQ-009 ref_done  input  1  one-cycle pulse: SDRAM controller finished auto-refresh.
REQ-010 host_gnt  output  1  host cycle may run (registered).
REQ-011 ref_gnt  output  1  auto-refresh may run (registered).
REQ-012 ref_pending  output  4  owed refreshes.
REQ-013 ref_overrun  output  1  sticky: a tick arrived while ref_pending == MAX_PENDING.
REQ-014 host_abort  output  1  one-cycle watchdog pulse.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be INIT, IDLE, HOST, REFRESH, GAP.
REQ-017 INIT: no grants, tick counter held at REF_INTERVAL-1, ref_pending 0; go to IDLE the cycle after init_done is sampled high.
REQ-018 Tick counter: outside INIT, decrement every cycle; at 0, reload REF_INTERVAL-1 and raise a one-cycle tick.
REQ-019 Tick: ref_pending+1, saturating at MAX_PENDING; a tick at saturation sets ref_overrun.
REQ-020 ref_done: ref_pending-1, never below 0; tick and ref_done in the same cycle leave ref_pending unchanged.
REQ-021 IDLE priority, highest first: ref_pending == MAX_PENDING -> REFRESH; host_req -> HOST; ref_pending > 0 -> REFRESH; else stay.
REQ-022 Latency: host_req sampled high in IDLE -> host_gnt high on the next cycle; same rule for ref_gnt.
REQ-023 HOST: host_gnt high until host_done is sampled, then GAP; host_req dropping mid-cycle does not end the grant.
REQ-024 REFRESH: ref_gnt high until ref_done is sampled, then GAP.
REQ-025 GAP: exactly one cycle with both grants low, then IDLE (bus turnaround).
REQ-026 host_gnt and ref_gnt never high in the same cycle.
REQ-027 host_done or ref_done arriving with no matching grant is ignored.
REQ-028 init_done falling outside INIT: return to INIT next cycle; grants drop; ref_pending cleared; ref_overrun held.

Reset
REQ-029 RESET_n low at a clock edge: state INIT; host_gnt 0; ref_gnt 0; ref_pending 0; ref_overrun 0; host_abort 0; busy 1; tick counter REF_INTERVAL-1.
REQ-030 Reset during HOST or REFRESH drops the grant on that same edge; no completion is required.

Configuration
REQ-031 Macro SDRAM_ARB_WATCHDOG_EN defined: a HOST cycle longer than HOST_TIMEOUT cycles without host_done goes to GAP, pulses host_abort for one cycle, and clears ref_overrun.
REQ-032 Macro SDRAM_ARB_WATCHDOG_EN undefined: no watchdog counter; host_abort tied 0; HOST waits indefinitely.

Structure
REQ-033 Shared package sdram_arb_pkg SHALL hold the state enum and the default values of REF_INTERVAL, MAX_PENDING and HOST_TIMEOUT.
REQ-034 Sub-module refresh_timer SHALL hold the tick counter and the ref_pending/ref_overrun logic; the arbiter FSM holds the rest.

Verification
REQ-035 Reset, init_done=1 at cycle 5, idle -> first tick 390 cycles after IDLE entry; ref_pending=1; ref_gnt next cycle.
REQ-036 host_req held, host_done 6 cycles after grant -> host_gnt exactly 6 cycles; one GAP cycle; busy low after.
REQ-037 Hold host_req with repeated 4-cycle host cycles; ref_pending reaches 8 -> REFRESH wins over host_req.
REQ-038 Block ref_done until ref_pending=8, one more tick -> ref_overrun=1; ref_pending stays 8.
REQ-039 Tick and ref_done in the same cycle with ref_pending=3 -> ref_pending stays 3.
REQ-040 Macro defined, host_done withheld 70 cycles -> host_abort pulses after 64 cycles; state GAP then IDLE. Macro undefined -> host_gnt held all 70 cycles.
